// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with ecall/mret/timer-interrupt trap sequencing.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTER_EN is defined.
module csr_trap_unit #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ecall,
    input  logic            mret,
    input  logic            irq_timer,
    input  logic            instr_retire,
    input  logic [XLEN-1:0] pc,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_target,
    output logic            illegal
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MISA    = 12'h301;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_MHARTID = 12'hF14;
`ifdef CSR_COUNTER_EN
    localparam logic [11:0] A_MCYC    = 12'hB00;
    localparam logic [11:0] A_MCYCH   = 12'hB80;
    localparam logic [11:0] A_MINST   = 12'hB02;
    localparam logic [11:0] A_MINSTH  = 12'hB82;
`endif

    logic            st_mie;
    logic            st_mpie;
    logic            mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-3:0] mepc_q;
    logic [XLEN-1:0] mcause;

    logic [XLEN-1:0] mstatus_v;
    logic [XLEN-1:0] mtvec_base;
    logic            impl;
    logic            ro;
    logic            wr_req;
    logic            csr_we;
    logic [XLEN-1:0] csr_nv;
    logic            take_ecall;
    logic            take_mret;
    logic            take_irq;

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        unused_pc;
    assign unused_pc = ^pc[1:0];
`else
    logic        unused_in;
    assign unused_in = ^{pc[1:0], instr_retire};
`endif

    assign mstatus_v  = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};

    // Address decode: read value and implemented/read-only attributes.
    always_comb begin
        csr_rdata = '0;
        impl      = 1'b1;
        ro        = 1'b0;
        unique case (1'b1)
            (csr_addr == A_MSTATUS): csr_rdata = mstatus_v;
            (csr_addr == A_MISA): begin
                csr_rdata = 32'h4000_0100;
                ro        = 1'b1;
            end
            (csr_addr == A_MIE):    csr_rdata = {24'b0, mtie, 7'b0};
            (csr_addr == A_MTVEC):  csr_rdata = mtvec;
            (csr_addr == A_MEPC):   csr_rdata = {mepc_q, 2'b00};
            (csr_addr == A_MCAUSE): csr_rdata = mcause;
            (csr_addr == A_MIP): begin
                csr_rdata = {24'b0, irq_timer, 7'b0};
                ro        = 1'b1;
            end
            (csr_addr == A_MHARTID): ro = 1'b1;
`ifdef CSR_COUNTER_EN
            (csr_addr == A_MCYC):   csr_rdata = mcycle[31:0];
            (csr_addr == A_MCYCH):  csr_rdata = mcycle[63:32];
            (csr_addr == A_MINST):  csr_rdata = minstret[31:0];
            (csr_addr == A_MINSTH): csr_rdata = minstret[63:32];
`endif
            default: impl = 1'b0;
        endcase
    end

    // Access legality and the read-modify-write result.
    always_comb begin
        wr_req  = (csr_op != 2'b00) && !(csr_op[1] && (csr_wdata == '0));
        illegal = !rst && (csr_op != 2'b00) && (!impl || (ro && wr_req));
        csr_nv  = csr_wdata;
        unique case (csr_op)
            2'b10:   csr_nv = csr_rdata | csr_wdata;
            2'b11:   csr_nv = csr_rdata & ~csr_wdata;
            default: csr_nv = csr_wdata;
        endcase
        csr_we = wr_req && !illegal && !trap_valid;
    end

    // Trap arbitration: ecall beats mret beats the timer interrupt.
    always_comb begin
        take_ecall  = !rst && ecall;
        take_mret   = !rst && mret && !ecall;
        take_irq    = !rst && !ecall && !mret && st_mie && mtie && irq_timer;
        trap_valid  = take_ecall || take_mret || take_irq;
        trap_target = '0;
        unique case (1'b1)
            take_ecall: trap_target = mtvec_base;
            take_mret:  trap_target = {mepc_q, 2'b00};
            take_irq:   trap_target = (mtvec[1:0] == 2'b01)
                                      ? mtvec_base + 32'd28 : mtvec_base;
            default:    trap_target = '0;
        endcase
    end

    // Architectural trap state and software CSR writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            mtie    <= 1'b0;
            mtvec   <= RESET_MTVEC;
            mepc_q  <= '0;
            mcause  <= '0;
        end else if (take_ecall || take_irq) begin
            mepc_q  <= pc[XLEN-1:2];
            mcause  <= take_ecall ? 32'd11 : 32'h8000_0007;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (take_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we) begin
            unique case (1'b1)
                (csr_addr == A_MSTATUS): begin
                    st_mie  <= csr_nv[3];
                    st_mpie <= csr_nv[7];
                end
                (csr_addr == A_MIE):    mtie   <= csr_nv[7];
                (csr_addr == A_MTVEC):  mtvec  <= csr_nv;
                (csr_addr == A_MEPC):   mepc_q <= csr_nv[XLEN-1:2];
                (csr_addr == A_MCAUSE): mcause <= csr_nv;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTER_EN
    // Free-running counters; a software write to a half wins over the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_addr == A_MCYC)
                mcycle[31:0] <= csr_nv;
            else if (csr_we && csr_addr == A_MCYCH)
                mcycle[63:32] <= csr_nv;
            else
                mcycle <= mcycle + 64'd1;
            if (csr_we && csr_addr == A_MINST)
                minstret[31:0] <= csr_nv;
            else if (csr_we && csr_addr == A_MINSTH)
                minstret[63:32] <= csr_nv;
            else if (instr_retire)
                minstret <= minstret + 64'd1;
        end
    end
`endif

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: CSR and datapath width; only 32 is supported.
REQ-002 SHALL have parameter RESET_MTVEC, default 32'h0: mtvec value at reset.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port csr_addr, input, 12: CSR address.
REQ-006 SHALL have port csr_op, input, 2: CSR operation. 00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
REQ-007 SHALL have port csr_wdata, input, XLEN: operand for RW/RS/RC.
REQ-008 SHALL have port csr_rdata, output, XLEN: current (pre-write) value of csr_addr.
REQ-009 SHALL have port ecall, input, 1: an ecall is executing this cycle.
REQ-010 SHALL have port mret, input, 1: an mret is executing this cycle.
REQ-011 SHALL have port irq_timer, input, 1: level-sensitive machine timer interrupt.
REQ-012 SHALL have port instr_retire, input, 1: one instruction retires this cycle.
REQ-013 SHALL have port pc, input, XLEN: PC of the current instruction.
REQ-014 SHALL have port trap_valid, output, 1: PC redirect required this cycle.
REQ-015 SHALL have port trap_target, output, XLEN: redirect address.
REQ-016 SHALL have port illegal, output, 1: the current CSR access is illegal.

Function
REQ-017 SHALL implement these CSRs:
- mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] fixed at 11; other bits read 0.
- misa 0x301: read-only 0x40000100.
- mie 0x304: MTIE bit7 only.
- mtvec 0x305.
- mepc 0x341: bits[1:0] read 0.
- mcause 0x342.
- mip 0x344: read-only, MTIP bit7 = irq_timer.
- mhartid 0xF14: read-only, reads 0.
REQ-018 SHALL drive csr_rdata combinationally from csr_addr regardless of csr_op; unimplemented addresses read 0.
REQ-019 SHALL compute the new value at the clock edge when csr_op!=00: RW = wdata; RS = old|wdata; RC = old&~wdata.
REQ-020 SHALL treat RS/RC with csr_wdata==0 as read-only: no write and no illegal.
REQ-021 SHALL assert illegal combinationally, and suppress the write, when csr_op!=00 and csr_addr is unimplemented, or when a read-only CSR is written.
REQ-022 SHALL, on ecall:
- set mepc<=pc, mcause<=11, MPIE<=MIE, MIE<=0;
- assert trap_valid in the same cycle with trap_target = {mtvec[31:2],2'b00}.
REQ-023 SHALL, on mret:
- set MIE<=MPIE, MPIE<=1;
- assert trap_valid with trap_target = mepc.
REQ-024 SHALL take an interrupt when MIE & MTIE & irq_timer and neither ecall nor mret is asserted:
- set mepc<=pc, mcause<=32'h80000007, MPIE<=MIE, MIE<=0;
- assert trap_valid.
REQ-025 SHALL use interrupt target {mtvec[31:2],2'b00}+28 when mtvec[1:0]==01 (vectored); otherwise the base. Exceptions always use the base.
REQ-026 SHALL apply priority ecall > mret > interrupt; the lower-priority event is ignored that cycle.
REQ-027 SHALL ignore the csr_op write (no state change, illegal still reported) in any cycle where trap_valid=1.
REQ-028 SHALL drive trap_valid=0 and trap_target=0 when no event occurs.
REQ-029 SHALL re-evaluate a still-pending interrupt each cycle; after taking it, MIE=0 masks it until mret or a software write.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set mstatus=0x1800, mtvec=RESET_MTVEC, mepc=0, mcause=0, mie=0, and counters=0.
REQ-031 SHALL hold trap_valid=0 and illegal=0 while rst=1; ecall, mret, csr_op and irq are ignored during reset.

Configuration
REQ-032 SHALL, when CSR_COUNTER_EN is defined, implement 64-bit mcycle and minstret counters:
- mcycle at 0xB00/0xB80 (low/high) increments every non-reset cycle;
- minstret at 0xB02/0xB82 increments when instr_retire=1;
- both wrap at 2^64;
- a CSR write to either half replaces that half and suppresses that counter's increment in that cycle.
REQ-033 SHALL, when CSR_COUNTER_EN is not defined, treat 0xB00/0xB80/0xB02/0xB82 as unimplemented (read 0; writes illegal) and contain no counter logic.

Verification
REQ-034 SHALL cover: after reset, read 0x300 -> 0x1800; read 0x305 -> RESET_MTVEC; trap_valid=0.
REQ-035 SHALL cover: RW 0x305=0x80000100, then ecall with pc=0x80000040 -> trap_target=0x80000100 in the same cycle; next cycle mepc=0x80000040, mcause=11, MIE=0.
REQ-036 SHALL cover: RS 0x300 wdata=0x8, RS 0x304 wdata=0x80, mtvec=0x80000101, irq_timer=1 -> trap_target=0x8000011C; mcause=0x80000007; the next cycle has no second trap.
REQ-037 SHALL cover: mret after REQ-036 -> trap_target=mepc; MIE=1; MPIE=1.
REQ-038 SHALL cover: RW 0xF14 -> illegal=1, value unchanged; RC 0x301 wdata=0 -> illegal=0; ecall and mret together -> ecall behaviour only.
REQ-039 SHALL cover, with CSR_COUNTER_EN: RW 0xB00=0xFFFFFFFF, 0xB80=0 -> two cycles later mcycleh=1; without CSR_COUNTER_EN, a read of 0xB00 returns 0 and RW 0xB00 gives illegal=1.
